// File: rtl/sig_debounce_if.sv
// Signal bundle between the raw trigger source and the debouncer.
// glitch_cnt is present only when SIG_DEBOUNCE_GLITCH_CNT_EN is defined.
interface sig_debounce_if
`ifdef SIG_DEBOUNCE_GLITCH_CNT_EN
    #(parameter int unsigned GLITCH_W = 8)
`endif
    ;
    logic sig_in;
    logic sig;
    logic rise;
    logic fall;
`ifdef SIG_DEBOUNCE_GLITCH_CNT_EN
    logic [GLITCH_W-1:0] glitch_cnt;
`endif

    modport master (
        output sig_in,
        input  sig,
        input  rise,
        input  fall
`ifdef SIG_DEBOUNCE_GLITCH_CNT_EN
        , input glitch_cnt
`endif
    );

    modport slave (
        input  sig_in,
        output sig,
        output rise,
        output fall
`ifdef SIG_DEBOUNCE_GLITCH_CNT_EN
        , output glitch_cnt
`endif
    );
endinterface

// File: rtl/sig_debounce.sv
// Two-flop synchroniser plus four-state debounce FSM producing a clean level and edge strobes.
// Optional saturating bounce counter compiled in with SIG_DEBOUNCE_GLITCH_CNT_EN.
module sig_debounce #(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned CNT_W      = 8
`ifdef SIG_DEBOUNCE_GLITCH_CNT_EN
    , parameter int unsigned GLITCH_W = 8
`endif
) (
    input logic           clk,
    input logic           rst,
    sig_debounce_if.slave bus
);
    typedef enum logic [1:0] {StLow, StRiseChk, StHigh, StFallChk} state_e;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEB_CYCLES - 1);

    logic             s1_q, s2_q;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sig_q, sig_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= StLow;
            cnt_q   <= '0;
            sig_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            s1_q    <= bus.sig_in;
            s2_q    <= s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sig_q   <= sig_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StLow: begin
                if (s2_q) begin
                    state_d = StRiseChk;
                    cnt_d   = CNT_W'(1);
                end
            end
            StRiseChk: begin
                if (!s2_q) begin
                    state_d = StLow;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = StHigh;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StHigh: begin
                if (!s2_q) begin
                    state_d = StFallChk;
                    cnt_d   = CNT_W'(1);
                end
            end
            StFallChk: begin
                if (s2_q) begin
                    state_d = StHigh;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = StLow;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StLow;
                cnt_d   = '0;
            end
        endcase
    end

    // Strobes fire only on the accepting edge; sig holds through every abort.
    always_comb begin
        rise_d = (state_q == StRiseChk) && s2_q && (cnt_q == CntLast);
        fall_d = (state_q == StFallChk) && !s2_q && (cnt_q == CntLast);
        sig_d  = sig_q;
        if (rise_d) begin
            sig_d = 1'b1;
        end else if (fall_d) begin
            sig_d = 1'b0;
        end
    end

    assign bus.sig  = sig_q;
    assign bus.rise = rise_q;
    assign bus.fall = fall_q;

`ifdef SIG_DEBOUNCE_GLITCH_CNT_EN
    logic                glitch;
    logic [GLITCH_W-1:0] glitch_cnt_q;

    assign glitch = ((state_q == StRiseChk) && !s2_q) || ((state_q == StFallChk) && s2_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            glitch_cnt_q <= '0;
        end else if (glitch && (glitch_cnt_q != '1)) begin
            glitch_cnt_q <= glitch_cnt_q + GLITCH_W'(1);
        end
    end

    assign bus.glitch_cnt = glitch_cnt_q;
`endif
endmodule

// File: tb/tb_sig_debounce.sv
// Scoreboard bench for sig_debounce: expected rise/fall strobes are queued with their edge number
// and popped by an independent monitor; level and glitch_cnt are checked directly.
module tb_sig_debounce;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   edge_cnt = 0;
    int   checks   = 0;
    int   failures = 0;

    typedef struct {
        logic is_rise;
        int   edge_no;
    } ev_t;
    ev_t exp_q[$];

`ifdef SIG_DEBOUNCE_GLITCH_CNT_EN
    sig_debounce_if #(.GLITCH_W(2)) bus ();
    sig_debounce #(.DEB_CYCLES(4), .CNT_W(8), .GLITCH_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
`else
    sig_debounce_if bus ();
    sig_debounce #(.DEB_CYCLES(4), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
`endif

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, req, edge_cnt);
        end
    endtask

    task automatic push(input logic is_rise, input int edge_no);
        ev_t ev;
        ev.is_rise = is_rise;
        ev.edge_no = edge_no;
        exp_q.push_back(ev);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.sig_in = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic check_glitch(input string name, input int req);
`ifdef SIG_DEBOUNCE_GLITCH_CNT_EN
        check(name, 32'(bus.glitch_cnt), 32'(req));
`endif
    endtask

    // Monitor: every strobe must match the head of the expected queue, kind and edge.
    always @(negedge clk) begin
        if (bus.rise || bus.fall) begin
            checks++;
            if (bus.rise && bus.fall) begin
                failures++;
                $display("FAIL strobe_overlap: rise=1 fall=1 at edge %0d, required at most one", edge_cnt);
            end else if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_strobe: rise=%0b fall=%0b at edge %0d, none expected",
                         bus.rise, bus.fall, edge_cnt);
            end else begin
                ev_t ev;
                ev = exp_q.pop_front();
                if ((ev.is_rise !== bus.rise) || (ev.edge_no != edge_cnt)) begin
                    failures++;
                    $display("FAIL strobe: got rise=%0b at edge %0d, expected rise=%0b at edge %0d",
                             bus.rise, edge_cnt, ev.is_rise, ev.edge_no);
                end
            end
        end
    end

    initial begin
        int exp_g[5] = '{1, 2, 3, 3, 3};
        logic seq[9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        bus.sig_in = 1'b0;
        tick();
        rst = 1'b0;

        // Scenario 1 / 5: clean step up then down
        do_reset();
        check("reset_sig", 32'(bus.sig), 0);
        check("reset_rise", 32'(bus.rise), 0);
        check("reset_fall", 32'(bus.fall), 0);
        check_glitch("reset_glitch", 0);
        bus.sig_in = 1'b1;
        push(1'b1, edge_cnt + 6);
        repeat (10) tick();
        check("step_up_sig", 32'(bus.sig), 1);
        check_glitch("step_up_glitch", 0);
        check("step_up_pending", 32'(exp_q.size()), 0);
        bus.sig_in = 1'b0;
        push(1'b0, edge_cnt + 6);
        repeat (10) tick();
        check("step_down_sig", 32'(bus.sig), 0);
        check("step_down_pending", 32'(exp_q.size()), 0);

        // Scenario 2: two-cycle pulse is rejected
        do_reset();
        bus.sig_in = 1'b1;
        repeat (2) tick();
        bus.sig_in = 1'b0;
        repeat (8) tick();
        check("pulse2_sig", 32'(bus.sig), 0);
        check_glitch("pulse2_glitch", 1);

        // Scenario 3: bouncy sequence with reset every tenth cycle
        do_reset();
        for (int it = 0; it < 5; it++) begin
            for (int j = 0; j < 9; j++) begin
                bus.sig_in = seq[j];
                tick();
            end
            check("bounce_sig", 32'(bus.sig), 0);
            check_glitch("bounce_glitch_pre", 1);
            rst = 1'b1;
            bus.sig_in = 1'b0;
            tick();
            rst = 1'b0;
            check_glitch("bounce_glitch_post", 0);
        end

        // Scenario 4: reset lands on the accepting edge
        do_reset();
        bus.sig_in = 1'b1;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_accept_sig", 32'(bus.sig), 0);
        check("rst_accept_rise", 32'(bus.rise), 0);
        push(1'b1, edge_cnt + 6);
        repeat (5) tick();
        check("reaccept_early_sig", 32'(bus.sig), 0);
        tick();
        check("reaccept_sig", 32'(bus.sig), 1);
        check("reaccept_rise", 32'(bus.rise), 1);
        bus.sig_in = 1'b0;
        push(1'b0, edge_cnt + 6);
        repeat (10) tick();
        check("reaccept_pending", 32'(exp_q.size()), 0);

        // Scenario 6: saturating glitch counter (2 bits)
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bus.sig_in = 1'b1;
            repeat (2) tick();
            bus.sig_in = 1'b0;
            repeat (6) tick();
            check("sat_sig", 32'(bus.sig), 0);
            check_glitch("sat_glitch", exp_g[i]);
        end

        repeat (3) tick();
        check("final_pending", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
